// File: rtl/lms_adaptive_fir_core.sv
// Sequential LMS adaptive FIR: one MAC per cycle for the filter and one tap update per cycle.
// Output is y or e. Weights can be frozen, cleared and read back.
module lms_adaptive_fir_core #(
    parameter int NUM_TAPS   = 8,
    parameter int DATA_W     = 16,
    parameter int COEF_W     = 18,
    parameter int MU_W       = 5,
    parameter int LEAK_SHIFT = 12
) (
    input  logic                        ce_clk,
    input  logic                        ce_rst_n,
    input  logic signed [DATA_W-1:0]    s_x_tdata,
    input  logic                        s_x_tvalid,
    output logic                        s_x_tready,
    input  logic signed [DATA_W-1:0]    s_d_tdata,
    input  logic                        s_d_tlast,
    input  logic                        s_d_tvalid,
    output logic                        s_d_tready,
    output logic signed [DATA_W-1:0]    m_tdata,
    output logic                        m_tlast,
    output logic                        m_tvalid,
    input  logic                        m_tready,
    input  logic [MU_W-1:0]             mu_shift,
    input  logic                        sign_err,
    input  logic                        leak_en,
    input  logic                        freeze,
    input  logic                        out_sel,
    input  logic                        clear_w,
    input  logic [$clog2(NUM_TAPS)-1:0] coef_rd_addr,
    output logic signed [COEF_W-1:0]    coef_rd_data,
    output logic                        busy
);

    localparam int AW      = $clog2(NUM_TAPS);
    localparam int MP_W    = DATA_W + COEF_W;
    localparam int ACC_W   = DATA_W + COEF_W + AW;
    localparam int PW      = 2 * DATA_W;
    localparam int SUM_W   = ((PW > COEF_W) ? PW : COEF_W) + 2;
    localparam int BASE_SH = 2 * (DATA_W - 1) - (COEF_W - 1);

    localparam logic signed [ACC_W-1:0]  D_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0]  D_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [SUM_W-1:0]  C_MAX = {{(SUM_W-COEF_W+1){1'b0}}, {(COEF_W-1){1'b1}}};
    localparam logic signed [SUM_W-1:0]  C_MIN = {{(SUM_W-COEF_W+1){1'b1}}, {(COEF_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] E_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] E_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, FILT, ERR, OUT, UPD} state_t;

    state_t                    state_q;
    logic signed [DATA_W-1:0]  xbuf_q [NUM_TAPS];
    logic signed [COEF_W-1:0]  w_q    [NUM_TAPS];
    logic signed [ACC_W-1:0]   acc_q;
    logic [AW-1:0]             k_q;
    logic signed [DATA_W-1:0]  d_q;
    logic signed [DATA_W-1:0]  e_q;
    logic [MU_W-1:0]           mu_q;
    logic                      tlast_q, sign_q, leak_q, freeze_q, out_sel_q, clr_pend_q;
    logic signed [DATA_W-1:0]  m_tdata_q;
    logic                      m_tlast_q, m_tvalid_q;
    logic signed [COEF_W-1:0]  coef_rd_q;

    logic                      accept, do_clear, k_last;
    logic signed [COEF_W-1:0]  w_cur, leak_amt, w_new;
    logic signed [DATA_W-1:0]  x_cur, y_sat, e_sat, e_prime;
    logic signed [MP_W-1:0]    mac_prod;
    logic signed [ACC_W-1:0]   acc_nxt;
    logic signed [PW-1:0]      upd_prod, upd_delta;
    logic [15:0]               upd_sh;
    logic signed [SUM_W-1:0]   w_ext, delta_ext, leak_ext, upd_sum;

    function automatic logic signed [DATA_W-1:0] sat_data(input logic signed [ACC_W-1:0] v);
        logic signed [DATA_W-1:0] r;
        if (v > D_MAX)      r = D_MAX[DATA_W-1:0];
        else if (v < D_MIN) r = D_MIN[DATA_W-1:0];
        else                r = v[DATA_W-1:0];
        return r;
    endfunction

    function automatic logic signed [COEF_W-1:0] sat_coef(input logic signed [SUM_W-1:0] v);
        logic signed [COEF_W-1:0] r;
        if (v > C_MAX)      r = C_MAX[COEF_W-1:0];
        else if (v < C_MIN) r = C_MIN[COEF_W-1:0];
        else                r = v[COEF_W-1:0];
        return r;
    endfunction

    // A pending or incoming clear blocks the accept for that cycle.
    assign do_clear   = (state_q == IDLE) && (clear_w || clr_pend_q);
    assign accept     = (state_q == IDLE) && s_x_tvalid && s_d_tvalid && !clear_w && !clr_pend_q;
    assign s_x_tready = accept;
    assign s_d_tready = accept;
    assign k_last     = (k_q == AW'(NUM_TAPS - 1));

    assign m_tdata      = m_tdata_q;
    assign m_tlast      = m_tlast_q;
    assign m_tvalid     = m_tvalid_q;
    assign coef_rd_data = coef_rd_q;
    assign busy         = (state_q != IDLE);

    always_comb begin
        w_cur    = w_q[k_q];
        x_cur    = xbuf_q[k_q];
        mac_prod = w_cur * x_cur;
        acc_nxt  = acc_q + $signed({{AW{mac_prod[MP_W-1]}}, mac_prod});
        y_sat    = sat_data(acc_q >>> (COEF_W - 1));
        e_sat    = sat_data($signed({{(ACC_W-DATA_W){d_q[DATA_W-1]}}, d_q})
                          - $signed({{(ACC_W-DATA_W){y_sat[DATA_W-1]}}, y_sat}));
        e_prime  = e_q;
        if (sign_q) begin
            if (e_q > 0)      e_prime = E_POS;
            else if (e_q < 0) e_prime = E_NEG;
            else              e_prime = '0;
        end
        upd_sh    = 16'(BASE_SH) + 16'(mu_q);
        upd_prod  = e_prime * x_cur;
        upd_delta = upd_prod >>> upd_sh;
        leak_amt  = w_cur >>> LEAK_SHIFT;
        w_ext     = $signed({{(SUM_W-COEF_W){w_cur[COEF_W-1]}}, w_cur});
        delta_ext = $signed({{(SUM_W-PW){upd_delta[PW-1]}}, upd_delta});
        leak_ext  = leak_q ? $signed({{(SUM_W-COEF_W){leak_amt[COEF_W-1]}}, leak_amt}) : '0;
        upd_sum   = w_ext + delta_ext - leak_ext;
        w_new     = sat_coef(upd_sum);
    end

    always_ff @(posedge ce_clk or negedge ce_rst_n) begin
        if (!ce_rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            k_q        <= '0;
            d_q        <= '0;
            e_q        <= '0;
            mu_q       <= '0;
            tlast_q    <= 1'b0;
            sign_q     <= 1'b0;
            leak_q     <= 1'b0;
            freeze_q   <= 1'b0;
            out_sel_q  <= 1'b0;
            clr_pend_q <= 1'b0;
            m_tdata_q  <= '0;
            m_tlast_q  <= 1'b0;
            m_tvalid_q <= 1'b0;
            coef_rd_q  <= '0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                xbuf_q[i] <= '0;
                w_q[i]    <= '0;
            end
        end else begin
            coef_rd_q <= w_q[coef_rd_addr];
            case (state_q)
                IDLE: begin
                    if (do_clear) begin
                        clr_pend_q <= 1'b0;
                        for (int i = 0; i < NUM_TAPS; i++) begin
                            xbuf_q[i] <= '0;
                            w_q[i]    <= '0;
                        end
                    end else if (accept) begin
                        for (int i = NUM_TAPS - 1; i > 0; i--) xbuf_q[i] <= xbuf_q[i-1];
                        xbuf_q[0] <= s_x_tdata;
                        d_q       <= s_d_tdata;
                        tlast_q   <= s_d_tlast;
                        mu_q      <= mu_shift;
                        sign_q    <= sign_err;
                        leak_q    <= leak_en;
                        freeze_q  <= freeze;
                        out_sel_q <= out_sel;
                        acc_q     <= '0;
                        k_q       <= '0;
                        state_q   <= FILT;
                    end
                end
                FILT: begin
                    acc_q <= acc_nxt;
                    k_q   <= k_q + 1'b1;
                    if (k_last) state_q <= ERR;
                end
                ERR: begin
                    e_q        <= e_sat;
                    m_tdata_q  <= out_sel_q ? e_sat : y_sat;
                    m_tlast_q  <= tlast_q;
                    m_tvalid_q <= 1'b1;
                    state_q    <= OUT;
                end
                OUT: begin
                    if (m_tready) begin
                        m_tvalid_q <= 1'b0;
                        k_q        <= '0;
                        state_q    <= freeze_q ? IDLE : UPD;
                    end
                end
                UPD: begin
                    w_q[k_q] <= w_new;
                    k_q      <= k_q + 1'b1;
                    if (k_last) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
            // A clear arriving mid-sample waits for the return to IDLE.
            if (state_q != IDLE && clear_w) clr_pend_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lms_adaptive_fir_core.sv
// Randomised bench for lms_adaptive_fir_core (4 taps) against a plain-arithmetic LMS model.
module tb_lms_adaptive_fir_core;

    localparam int NT = 4;
    localparam int DW = 16;
    localparam int CW = 18;
    localparam int MW = 5;

    logic          ce_clk;
    logic          ce_rst_n;
    logic [DW-1:0] s_x_tdata;
    logic          s_x_tvalid;
    logic          s_x_tready;
    logic [DW-1:0] s_d_tdata;
    logic          s_d_tlast;
    logic          s_d_tvalid;
    logic          s_d_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tlast;
    logic          m_tvalid;
    logic          m_tready;
    logic [MW-1:0] mu_shift;
    logic          sign_err, leak_en, freeze, out_sel, clear_w;
    logic [1:0]    coef_rd_addr;
    logic [CW-1:0] coef_rd_data;
    logic          busy;

    int errors = 0;
    int checks = 0;

    longint w_m  [NT];
    longint xb_m [NT];

    lms_adaptive_fir_core #(
        .NUM_TAPS(NT), .DATA_W(DW), .COEF_W(CW), .MU_W(MW), .LEAK_SHIFT(12)
    ) dut (
        .ce_clk(ce_clk), .ce_rst_n(ce_rst_n),
        .s_x_tdata(s_x_tdata), .s_x_tvalid(s_x_tvalid), .s_x_tready(s_x_tready),
        .s_d_tdata(s_d_tdata), .s_d_tlast(s_d_tlast), .s_d_tvalid(s_d_tvalid), .s_d_tready(s_d_tready),
        .m_tdata(m_tdata), .m_tlast(m_tlast), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .mu_shift(mu_shift), .sign_err(sign_err), .leak_en(leak_en), .freeze(freeze),
        .out_sel(out_sel), .clear_w(clear_w),
        .coef_rd_addr(coef_rd_addr), .coef_rd_data(coef_rd_data), .busy(busy)
    );

    initial ce_clk = 1'b0;
    always #5 ce_clk = ~ce_clk;

    // ---------------- reference model ----------------
    function automatic longint sat(input longint v, input longint lo, input longint hi);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NT; i++) begin
            w_m[i]  = 0;
            xb_m[i] = 0;
        end
    endfunction

    function automatic int model_pair(input longint x, input longint d, input int mu,
                                      input bit sgn, input bit lk, input bit frz, input bit osel);
        longint acc, y, e, ep, delta;
        for (int i = NT - 1; i > 0; i--) xb_m[i] = xb_m[i-1];
        xb_m[0] = x;
        acc = 0;
        for (int k = 0; k < NT; k++) acc += w_m[k] * xb_m[k];
        y = sat(acc >>> 17, -32768, 32767);
        e = sat(d - y, -32768, 32767);
        if (!frz) begin
            ep = e;
            if (sgn) ep = (e > 0) ? 32767 : ((e < 0) ? -32768 : 0);
            for (int k = 0; k < NT; k++) begin
                delta  = (ep * xb_m[k]) >>> (13 + mu);
                w_m[k] = sat(w_m[k] + delta - (lk ? (w_m[k] >>> 12) : 0), -131072, 131071);
            end
        end
        return int'(osel ? e : y);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_pair(input int x, input int d, input bit last, input bit osel, input int mu,
                           input bit sgn, input bit lk, input bit frz,
                           output int got, output bit got_last, output int lat);
        int n;
        got = 0; got_last = 0; lat = 0;
        s_x_tdata = DW'(x); s_d_tdata = DW'(d); s_d_tlast = last;
        mu_shift = MW'(mu); sign_err = sgn; leak_en = lk; freeze = frz; out_sel = osel;
        s_x_tvalid = 1'b1; s_d_tvalid = 1'b1;
        #1;
        n = 0;
        while (!s_x_tready && n < 200) begin @(negedge ce_clk); #1; n++; end
        if (!s_x_tready) begin
            checks++; errors++;
            $display("FAIL accept_timeout s_x_tready=%0b exp=1", s_x_tready);
            s_x_tvalid = 1'b0; s_d_tvalid = 1'b0;
            return;
        end
        @(posedge ce_clk); #1;
        s_x_tvalid = 1'b0; s_d_tvalid = 1'b0;
        n = 0;
        while (!m_tvalid && n < 200) begin @(negedge ce_clk); n++; end
        if (!m_tvalid) begin
            checks++; errors++;
            $display("FAIL output_timeout m_tvalid=%0b exp=1", m_tvalid);
            return;
        end
        lat = n;
        got = int'($signed(m_tdata));
        got_last = m_tlast;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin @(negedge ce_clk); n++; end
        if (busy) begin
            checks++; errors++;
            $display("FAIL idle_timeout busy=%0b exp=0", busy);
        end
    endtask

    task automatic read_w(input int k, output int v);
        coef_rd_addr = 2'(k);
        repeat (2) @(negedge ce_clk);
        v = int'($signed(coef_rd_data));
    endtask

    task automatic pulse_clear();
        wait_idle();
        clear_w = 1'b1;
        @(negedge ce_clk);
        clear_w = 1'b0;
        model_clear();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        checks++;
        if ({m_tvalid, m_tlast, busy, s_x_tready, s_d_tready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl got=%b exp=00000", {m_tvalid, m_tlast, busy, s_x_tready, s_d_tready});
        end
        checks++;
        if (m_tdata !== '0) begin errors++; $display("FAIL reset_tdata got=%0d exp=0", m_tdata); end
        checks++;
        if (coef_rd_data !== '0) begin errors++; $display("FAIL reset_coef got=%0d exp=0", coef_rd_data); end
    endtask

    task automatic test_basic();
        int got, lat, exp, v;
        bit gl;
        exp = model_pair(1000, 2000, 4, 0, 0, 0, 1);
        do_pair(1000, 2000, 0, 1, 4, 0, 0, 0, got, gl, lat);
        checks++;
        if (got !== 2000 || got !== exp) begin errors++; $display("FAIL basic_e got=%0d exp=%0d", got, exp); end
        checks++;
        if (lat !== NT + 2) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", lat, NT + 2); end
        checks++;
        if (gl !== 1'b0) begin errors++; $display("FAIL basic_tlast got=%0b exp=0", gl); end
        wait_idle();
        read_w(0, v);
        checks++;
        if (v !== 15 || longint'(v) !== w_m[0]) begin errors++; $display("FAIL basic_w0 got=%0d exp=15", v); end
    endtask

    task automatic test_back_to_back();
        int got, lat, exp;
        bit gl;
        m_tready = 1'b0;
        exp = model_pair(-3000, 500, 4, 0, 0, 0, 0);
        do_pair(-3000, 500, 1, 0, 4, 0, 0, 0, got, gl, lat);
        checks++;
        if (got !== exp || gl !== 1'b1) begin errors++; $display("FAIL bp_first got=%0d/%0b exp=%0d/1", got, gl, exp); end
        checks++;
        if (lat !== NT + 2) begin errors++; $display("FAIL bp_latency got=%0d exp=%0d", lat, NT + 2); end
        s_x_tdata = DW'(1234); s_d_tdata = DW'(77); s_d_tlast = 1'b0;
        s_x_tvalid = 1'b1; s_d_tvalid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge ce_clk);
            checks++;
            if (m_tvalid !== 1'b1 || int'($signed(m_tdata)) !== exp || m_tlast !== 1'b1 || s_x_tready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got=%0b/%0d/%0b/%0b exp=1/%0d/1/0",
                         i, m_tvalid, $signed(m_tdata), m_tlast, s_x_tready, exp);
            end
        end
        s_x_tvalid = 1'b0; s_d_tvalid = 1'b0;
        m_tready = 1'b1;
        @(negedge ce_clk);
        checks++;
        if (m_tvalid !== 1'b0) begin errors++; $display("FAIL bp_release got=%0b exp=0", m_tvalid); end
        wait_idle();
    endtask

    task automatic test_sign_error();
        int got, lat, exp, v;
        bit gl;
        pulse_clear();
        exp = model_pair(4096, 100, 4, 1, 0, 0, 1);
        do_pair(4096, 100, 0, 1, 4, 1, 0, 0, got, gl, lat);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL sign_e got=%0d exp=%0d", got, exp); end
        wait_idle();
        for (int k = 0; k < NT; k++) begin
            read_w(k, v);
            checks++;
            if (v !== ((k == 0) ? 1023 : 0)) begin
                errors++; $display("FAIL sign_w%0d got=%0d exp=%0d", k, v, (k == 0) ? 1023 : 0);
            end
        end
    endtask

    task automatic test_clear_collision();
        wait_idle();
        s_x_tdata = DW'(500); s_d_tdata = DW'(500);
        s_x_tvalid = 1'b1; s_d_tvalid = 1'b1; clear_w = 1'b1;
        #1;
        checks++;
        if (s_x_tready !== 1'b0 || s_d_tready !== 1'b0) begin
            errors++; $display("FAIL clear_wins got=%0b%0b exp=00", s_x_tready, s_d_tready);
        end
        @(negedge ce_clk);
        clear_w = 1'b0;
        #1;
        checks++;
        if (s_x_tready !== 1'b1) begin errors++; $display("FAIL clear_defer got=%0b exp=1", s_x_tready); end
        s_x_tvalid = 1'b0; s_d_tvalid = 1'b0;
        model_clear();
        @(negedge ce_clk);
    endtask

    task automatic test_sysid();
        int got, lat, exp, x, prev_x, max_e, bad, v;
        bit gl;
        pulse_clear();
        prev_x = 0; max_e = 0; bad = 0;
        for (int n = 0; n < 3000; n++) begin
            x = int'($urandom_range(16000, 0)) - 8000;
            exp = model_pair(x, prev_x, 2, 0, 0, 0, 1);
            do_pair(x, prev_x, 0, 1, 2, 0, 0, 0, got, gl, lat);
            checks++;
            if (got !== exp) begin
                errors++;
                if (bad < 5) $display("FAIL sysid_e n=%0d got=%0d exp=%0d", n, got, exp);
                bad++;
            end
            if (n >= 2900 && (got > max_e || -got > max_e)) max_e = (got < 0) ? -got : got;
            prev_x = x;
        end
        checks++;
        if (max_e >= 64) begin errors++; $display("FAIL sysid_conv got=%0d exp=<64", max_e); end
        wait_idle();
        read_w(1, v);
        checks++;
        if (v < 131071 - 1311) begin errors++; $display("FAIL sysid_w1 got=%0d exp=131071+-1%%", v); end
        for (int k = 0; k < NT; k++) begin
            read_w(k, v);
            checks++;
            if (longint'(v) !== w_m[k]) begin errors++; $display("FAIL sysid_wm%0d got=%0d exp=%0d", k, v, w_m[k]); end
        end
    endtask

    task automatic test_freeze();
        int got, lat, exp, x, d, v;
        bit gl, osel;
        longint snap [NT];
        for (int k = 0; k < NT; k++) snap[k] = w_m[k];
        for (int n = 0; n < 50; n++) begin
            x = int'($urandom_range(65535, 0)) - 32768;
            d = int'($urandom_range(65535, 0)) - 32768;
            osel = 1'($urandom_range(1, 0));
            exp = model_pair(x, d, 3, 0, 0, 1, osel);
            do_pair(x, d, 0, osel, 3, 0, 0, 1, got, gl, lat);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL freeze_out n=%0d got=%0d exp=%0d", n, got, exp); end
        end
        wait_idle();
        for (int k = 0; k < NT; k++) begin
            read_w(k, v);
            checks++;
            if (longint'(v) !== snap[k]) begin errors++; $display("FAIL freeze_w%0d got=%0d exp=%0d", k, v, snap[k]); end
        end
    endtask

    task automatic test_clear_mid_filt();
        int got, exp, n, v;
        wait_idle();
        exp = model_pair(-12000, 9000, 5, 0, 0, 0, 0);
        s_x_tdata = DW'(-12000); s_d_tdata = DW'(9000); s_d_tlast = 1'b0;
        mu_shift = MW'(5); sign_err = 1'b0; leak_en = 1'b0; freeze = 1'b0; out_sel = 1'b0;
        s_x_tvalid = 1'b1; s_d_tvalid = 1'b1;
        @(posedge ce_clk); #1;
        s_x_tvalid = 1'b0; s_d_tvalid = 1'b0;
        @(negedge ce_clk);
        clear_w = 1'b1;
        @(negedge ce_clk);
        clear_w = 1'b0;
        n = 0;
        while (!m_tvalid && n < 50) begin @(negedge ce_clk); n++; end
        got = int'($signed(m_tdata));
        checks++;
        if (m_tvalid !== 1'b1 || got !== exp) begin
            errors++; $display("FAIL clrmid_out got=%0b/%0d exp=1/%0d", m_tvalid, got, exp);
        end
        model_clear();
        wait_idle();
        for (int k = 0; k < NT; k++) begin
            read_w(k, v);
            checks++;
            if (v !== 0) begin errors++; $display("FAIL clrmid_w%0d got=%0d exp=0", k, v); end
        end
    endtask

    task automatic test_random_modes();
        int got, lat, exp, x, d, mu, v;
        bit gl, osel, sgn, lk, last;
        for (int n = 0; n < 40; n++) begin
            x = int'($urandom_range(65535, 0)) - 32768;
            d = int'($urandom_range(65535, 0)) - 32768;
            mu = int'($urandom_range(8, 0));
            osel = 1'($urandom_range(1, 0)); sgn = 1'($urandom_range(1, 0));
            lk = 1'($urandom_range(1, 0)); last = 1'($urandom_range(1, 0));
            exp = model_pair(x, d, mu, sgn, lk, 0, osel);
            do_pair(x, d, last, osel, mu, sgn, lk, 0, got, gl, lat);
            checks++;
            if (got !== exp || gl !== last) begin
                errors++; $display("FAIL rand_out n=%0d got=%0d/%0b exp=%0d/%0b", n, got, gl, exp, last);
            end
        end
        wait_idle();
        for (int k = 0; k < NT; k++) begin
            read_w(k, v);
            checks++;
            if (longint'(v) !== w_m[k]) begin errors++; $display("FAIL rand_w%0d got=%0d exp=%0d", k, v, w_m[k]); end
        end
    endtask

    task automatic test_saturation();
        int got, lat, exp, v;
        bit gl;
        pulse_clear();
        for (int n = 0; n < 2; n++) begin
            exp = model_pair(32767, -32768, 0, 0, 0, 0, 1);
            do_pair(32767, -32768, 0, 1, 0, 0, 0, 0, got, gl, lat);
            checks++;
            if (got !== exp) begin errors++; $display("FAIL sat_pre n=%0d got=%0d exp=%0d", n, got, exp); end
        end
        wait_idle();
        read_w(0, v);
        checks++;
        if (v !== -131072) begin errors++; $display("FAIL sat_w0 got=%0d exp=-131072", v); end
        exp = model_pair(32767, 32767, 0, 0, 0, 0, 1);
        do_pair(32767, 32767, 0, 1, 0, 0, 0, 0, got, gl, lat);
        checks++;
        if (got !== 32767 || got !== exp) begin errors++; $display("FAIL sat_e got=%0d exp=32767", got); end
        wait_idle();
    endtask

    task automatic test_reset_mid_out();
        int got, lat, exp, v;
        bit gl;
        m_tready = 1'b0;
        exp = model_pair(2222, -1111, 3, 0, 0, 0, 1);
        do_pair(2222, -1111, 1, 1, 3, 0, 0, 0, got, gl, lat);
        checks++;
        if (got !== exp) begin errors++; $display("FAIL rst_pre got=%0d exp=%0d", got, exp); end
        #2;
        ce_rst_n = 1'b0;
        #1;
        checks++;
        if (m_tvalid !== 1'b0 || busy !== 1'b0 || m_tdata !== '0) begin
            errors++; $display("FAIL rst_async got=%0b/%0b/%0d exp=0/0/0", m_tvalid, busy, m_tdata);
        end
        @(negedge ce_clk);
        ce_rst_n = 1'b1;
        m_tready = 1'b1;
        model_clear();
        for (int k = 0; k < NT; k++) begin
            read_w(k, v);
            checks++;
            if (v !== 0) begin errors++; $display("FAIL rst_w%0d got=%0d exp=0", k, v); end
        end
    endtask

    initial begin
        ce_rst_n = 1'b0;
        s_x_tdata = '0; s_x_tvalid = 1'b0; s_d_tdata = '0; s_d_tlast = 1'b0; s_d_tvalid = 1'b0;
        m_tready = 1'b1; mu_shift = '0; sign_err = 1'b0; leak_en = 1'b0; freeze = 1'b0;
        out_sel = 1'b0; clear_w = 1'b0; coef_rd_addr = '0;
        model_clear();
        repeat (3) @(negedge ce_clk);
        ce_rst_n = 1'b1;
        @(negedge ce_clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_sign_error();
        test_clear_collision();
        test_sysid();
        test_freeze();
        test_clear_mid_filt();
        test_random_modes();
        test_saturation();
        test_reset_mid_out();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
